ihp_sram_port_ctrl: RTL and testbench

IHP_SRAM_PORT_CTRL -- requirements
Module: ihp_sram_port_ctrl

---
 rtl/ihp_sram_port_ctrl.sv | 112 +++++++++++
 tb/tb_ihp_sram_port_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ihp_sram_port_ctrl.sv
// Single-port SRAM macro controller: fabric request in, macro strobes out.
// One request in flight; reads return one cycle after the macro access.
module ihp_sram_port_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024
) (
  input  logic              UserCLK,
  input  logic              RST,
  input  logic              REQ,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W-1:0] BM,
  output logic              READY,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] RDATA,
  output logic [ADDR_W-1:0] A_ADDR,
  output logic [DATA_W-1:0] A_DIN,
  output logic [DATA_W-1:0] A_BM,
  output logic              A_MEN,
  output logic              A_WEN,
  output logic              A_REN,
  input  logic [DATA_W-1:0] A_DOUT
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  // One extra bit so DEPTH == 2^ADDR_W is representable
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] bm_q, bm_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              in_range;

  assign in_range = ({1'b0, addr_q} < DEPTH_C);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bm_d    = bm_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          addr_d  = ADDR;
          wdata_d = WDATA;
          bm_d    = BM;
          we_d    = WE;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q || !in_range) state_d = RESP;
        else                   state_d = WAIT;
      end
      WAIT: begin
        rdata_d = A_DOUT;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      bm_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bm_q    <= bm_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
    end
  end

  assign READY  = (state_q == IDLE);
  assign DONE   = (state_q == RESP);
  // Address is still held in RESP, so the range check is reused there
  assign ERR    = (state_q == RESP) && !in_range;
  assign RDATA  = rdata_q;
  assign A_ADDR = addr_q;
  assign A_DIN  = wdata_q;
  assign A_BM   = bm_q;
  assign A_MEN  = (state_q == ACCESS) && in_range;
  assign A_WEN  = A_MEN && we_q;
  assign A_REN  = A_MEN && !we_q;

endmodule

// File: tb/tb_ihp_sram_port_ctrl.sv
// Directed bench for ihp_sram_port_ctrl with a behavioural macro model.
// Expected completions are queued at request time and checked at DONE.
module tb_ihp_sram_port_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int DP = 1000;

  logic          clk = 1'b0;
  logic          RST, REQ, WE;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] WDATA, BM;
  logic          READY, DONE, ERR;
  logic [DW-1:0] RDATA;
  logic [AW-1:0] A_ADDR;
  logic [DW-1:0] A_DIN, A_BM;
  logic          A_MEN, A_WEN, A_REN;
  logic [DW-1:0] A_DOUT;

  ihp_sram_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
    .UserCLK(clk), .RST(RST), .REQ(REQ), .WE(WE), .ADDR(ADDR),
    .WDATA(WDATA), .BM(BM), .READY(READY), .DONE(DONE), .ERR(ERR),
    .RDATA(RDATA), .A_ADDR(A_ADDR), .A_DIN(A_DIN), .A_BM(A_BM),
    .A_MEN(A_MEN), .A_WEN(A_WEN), .A_REN(A_REN), .A_DOUT(A_DOUT)
  );

  always #5 clk = ~clk;

  // Behavioural macro: masked write, registered read output
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] dout_q = '0;
  int            men_cnt = 0;
  assign A_DOUT = dout_q;

  always @(posedge clk) begin
    if (A_MEN) begin
      men_cnt <= men_cnt + 1;
      if (A_WEN) mem[A_ADDR] <= (mem[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
      if (A_REN) dout_q <= mem[A_ADDR];
    end
  end

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] rd_model = '0;
  int            n_assert = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE; returns in the cycle after DONE
  task automatic op(input logic we, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [DW-1:0] m);
    exp_t e;
    int   lat;
    int   men0;
    logic inr;
    inr = (int'(a) < DP);
    chk("ready_idle", 32'(READY), 32'd1);
    REQ = 1'b1; WE = we; ADDR = a; WDATA = d; BM = m;
    e.err = !inr;
    e.lat = (we || !inr) ? 2 : 3;
    if (!we && inr) rd_model = ref_mem[a];
    if (we && inr) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
    e.rdata = rd_model;
    sb.push_back(e);
    men0 = men_cnt;
    step();
    REQ = 1'b0;
    lat = 1;
    chk("acc_men", 32'(A_MEN), 32'(inr));
    chk("acc_wen", 32'(A_WEN), 32'(inr && we));
    chk("acc_ren", 32'(A_REN), 32'(inr && !we));
    chk("acc_addr", 32'(A_ADDR), 32'(a));
    chk("acc_bm", A_BM, m);
    chk("acc_ready", 32'(READY), 32'd0);
    while (!DONE && lat < 8) begin
      step();
      lat++;
    end
    e = sb.pop_front();
    chk("done_seen", 32'(DONE), 32'd1);
    chk("latency", 32'(lat), 32'(e.lat));
    chk("err", 32'(ERR), 32'(e.err));
    chk("rdata", RDATA, e.rdata);
    chk("men_pulses", 32'(men_cnt - men0), 32'(inr));
    step();
    chk("done_pulse", 32'(DONE), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    RST = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR = '0; WDATA = '0; BM = '0;
    step();
    step();
    chk("rst_ready", 32'(READY), 32'd1);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_men", 32'(A_MEN), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    chk("rst_addr", 32'(A_ADDR), 32'd0);
    chk("rst_bm", A_BM, 32'd0);
    RST = 1'b0;
    step();

    op(1'b1, 10'h005, 32'hDEADBEEF, 32'hFFFFFFFF);
    op(1'b0, 10'h005, 32'h0, 32'h0);
    chk("rd_deadbeef", RDATA, 32'hDEADBEEF);
    op(1'b1, 10'h005, 32'h00000000, 32'h0000FFFF);
    op(1'b0, 10'h005, 32'h0, 32'h0);
    chk("rd_masked", RDATA, 32'hDEAD0000);

    op(1'b0, 10'd1000, 32'h0, 32'h0);
    chk("oor_hold", RDATA, 32'hDEAD0000);
    op(1'b1, 10'd1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    op(1'b1, 10'd999, 32'hA5A5_5A5A, 32'hFFFFFFFF);
    op(1'b0, 10'd999, 32'h0, 32'h0);
    chk("rd_999", RDATA, 32'hA5A55A5A);

    // REQ held high: accepts only in IDLE, every third cycle
    begin
      int men0;
      int acc;
      int dn;
      men0 = men_cnt;
      acc = 0;
      dn = 0;
      REQ = 1'b1; WE = 1'b1; ADDR = 10'd20;
      WDATA = 32'h12345678; BM = 32'hFFFFFFFF;
      for (int i = 0; i < 12; i++) begin
        chk("burst_ready", 32'(READY), 32'((i % 3) == 0));
        if (READY) acc++;
        if (DONE) dn++;
        step();
      end
      REQ = 1'b0;
      if (DONE) dn++;
      chk("burst_acc", 32'(acc), 32'd4);
      chk("burst_done", 32'(dn), 32'd4);
      chk("burst_men", 32'(men_cnt - men0), 32'd4);
      ref_mem[20] = 32'h12345678;
      step();
    end
    op(1'b0, 10'd20, 32'h0, 32'h0);

    // Reset in the WAIT cycle of a read aborts it
    begin
      int dn;
      REQ = 1'b1; WE = 1'b0; ADDR = 10'h005;
      step();
      REQ = 1'b0;
      step();
      chk("abort_wait", 32'(DONE || READY || A_MEN), 32'd0);
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk("abort_done", 32'(DONE), 32'd0);
      chk("abort_rdata", RDATA, 32'd0);
      chk("abort_ready", 32'(READY), 32'd1);
      dn = 0;
      for (int i = 0; i < 3; i++) begin
        step();
        if (DONE) dn++;
      end
      chk("abort_nodone", 32'(dn), 32'd0);
      rd_model = '0;
    end
    op(1'b1, 10'h033, 32'hCAFEF00D, 32'hFFFF0000);
    op(1'b0, 10'h033, 32'h0, 32'h0);
    chk("rd_after_rst", RDATA, 32'hCAFE0000);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
